// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets shared by the gpio register block and the
// gpio_in_cond input-conditioning block. Both decode word offsets from
// addr[3:2] on the same simple memory bus.
package gpio_pkg;

    // gpio register block offsets
    localparam logic [1:0] GPIO_REG_GPEN = 2'b00;
    localparam logic [1:0] GPIO_REG_GPO  = 2'b01;
    localparam logic [1:0] GPIO_REG_GPI  = 2'b10;

    // gpio_in_cond register offsets
    typedef enum logic [1:0] {
        REG_LIMIT = 2'b00,  // debounce limit, R/W
        REG_MASK  = 2'b01,  // interrupt mask, R/W
        REG_PEND  = 2'b10,  // edge pending, read / write-1-to-clear
        REG_RAW   = 2'b11   // synchronized pad value, read-only
    } cond_reg_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: conditioning for one GPIO input bit.
//   2-flop synchronizer -> debouncer -> stable flop, plus a toggle pulse
//   that is high during the cycle whose closing edge flips stable.
// Optional feature macro: GPIO_IN_DEBOUNCE_EN. When undefined the counter
// and limit port disappear and stable simply follows the synchronizer.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   pin              raw asynchronous pad input
//   limit            debounce limit (only with GPIO_IN_DEBOUNCE_EN)
//   raw              synchronized pin (second synchronizer flop)
//   stable           debounced value
//   toggle           stable will change on the next edge
module gpio_debounce_bit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pin,
`ifdef GPIO_IN_DEBOUNCE_EN
    input  logic [CNT_W-1:0] limit,
`endif
    output logic             raw,
    output logic             stable,
    output logic             toggle
);

    logic sync1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source (sync1 -> raw is a shift).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            raw   <= 1'b0;
        end else begin
            sync1 <= pin;
            raw   <= sync1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;

    // The counter holds how many consecutive edges raw has already
    // disagreed with stable; the edge on which it equals limit commits.
    assign toggle = (raw != stable) && (cnt == limit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            cnt    <= '0;
        end else if (cnt == limit) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            // Wraps at 2^CNT_W if limit was lowered below a running count.
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign toggle = (raw != stable);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable <= 1'b0;
        end else begin
            stable <= raw;
        end
    end
`endif

endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input conditioning between the GPIO pads and gpio.gpi.
//   Per bit: synchronizer + programmable debouncer (gpio_debounce_bit).
//   Edges of the debounced value latch into PEND; irq = |(PEND & MASK),
//   registered. Registers on the simple memory bus, word offset addr[3:2]:
//   LIMIT (R/W), MASK (R/W), PEND (R/W1C), RAW (RO).
// Optional feature macro: GPIO_IN_DEBOUNCE_EN. Undefined: no counters or
// LIMIT register, LIMIT reads 0, gpi follows the synchronizer directly.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   mem_valid, mem_ready   bus request / one-cycle acknowledge
//   data, addr, we         write data, byte address, write enable
//   q                      read data (0 when mem_valid is low)
//   pin_in                 raw asynchronous pad inputs
//   gpi                    debounced inputs, feeds gpio.gpi
//   irq                    interrupt request
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int unsigned           GPIO_WIDTH  = 4,
    parameter int unsigned           CNT_W       = 16,
    parameter logic [CNT_W-1:0]      RESET_LIMIT = CNT_W'(1000)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [31:0]           data,
    input  logic [31:0]           addr,
    input  logic                  we,
    output logic [31:0]           q,
    input  logic [GPIO_WIDTH-1:0] pin_in,
    output logic [GPIO_WIDTH-1:0] gpi,
    output logic                  irq
);

    cond_reg_e             reg_sel;
    logic                  wr_en;
    logic [GPIO_WIDTH-1:0] raw;
    logic [GPIO_WIDTH-1:0] stable;
    logic [GPIO_WIDTH-1:0] toggle;
    logic [GPIO_WIDTH-1:0] mask_q;
    logic [GPIO_WIDTH-1:0] pend_q;
    logic [GPIO_WIDTH-1:0] pend_clr;
    logic [31:0]           limit_rd;
    logic                  unused_bus_bits;

    assign reg_sel  = cond_reg_e'(addr[3:2]);
    assign wr_en    = mem_valid && we;
    assign pend_clr = (wr_en && reg_sel == REG_PEND) ? data[GPIO_WIDTH-1:0] : '0;
    assign gpi      = stable;

    // Only addr[3:2] and the low data bits are decoded.
    assign unused_bus_bits = ^{addr, data};

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [CNT_W-1:0] limit_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            limit_q <= RESET_LIMIT;
        end else if (wr_en && reg_sel == REG_LIMIT) begin
            limit_q <= data[CNT_W-1:0];
        end
    end

    assign limit_rd = 32'(limit_q);
`else
    assign limit_rd = '0;
`endif

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .pin    (pin_in[i]),
`ifdef GPIO_IN_DEBOUNCE_EN
            .limit  (limit_q),
`endif
            .raw    (raw[i]),
            .stable (stable[i]),
            .toggle (toggle[i])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q    <= '0;
            pend_q    <= '0;
            irq       <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_valid;
            if (wr_en && reg_sel == REG_MASK) begin
                mask_q <= data[GPIO_WIDTH-1:0];
            end
            // A new edge wins over a simultaneous write-1-to-clear.
            pend_q <= (pend_q & ~pend_clr) | toggle;
            irq    <= |(pend_q & mask_q);
        end
    end

    // NOTE: q gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        q = '0;
        if (mem_valid) begin
            unique case (reg_sel)
                REG_LIMIT: q = limit_rd;
                REG_MASK:  q = 32'(mask_q);
                REG_PEND:  q = 32'(pend_q);
                REG_RAW:   q = 32'(raw);
            endcase
        end
    end

endmodule
